dev_endpoint: RTL

//  Device-side endpoint that sits directly upstream/downstream of one switch-side port.
//  TX: buffers host words plus 3-bit destination and presents them to the port's

---
 rtl/ep_pkg.sv | 20 ++
 rtl/dev_endpoint_if.sv | 25 ++
 rtl/ep_fifo.sv | 46 ++++
 rtl/dev_endpoint.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/ep_pkg.sv
// Shared types and constants for the device endpoint: destination width and the
// TX/RX handshake state encodings.
package ep_pkg;

    localparam int ADR_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        REQ,
        GAP
    } tx_state_t;

    typedef enum logic [1:0] {
        RIDLE,
        RACK,
        RWAIT
    } rx_state_t;

endpackage

// File: rtl/dev_endpoint_if.sv
// Switch-port side of the endpoint: TX frame handshake (validtx/acktx) and
// RX frame handshake (validrx/ackrx). The endpoint is the master.
interface dev_endpoint_if #(
    parameter int DW = 4
);

    logic                        validtx_o;
    logic [ep_pkg::ADR_W-1:0]    adr_o;
    logic [DW-1:0]               dat_o;
    logic                        acktx_i;
    logic                        validrx_i;
    logic [DW+ep_pkg::ADR_W-1:0] dat_i;
    logic                        ackrx_o;

    modport master (
        output validtx_o, adr_o, dat_o, ackrx_o,
        input  acktx_i, validrx_i, dat_i
    );

    modport slave (
        input  validtx_o, adr_o, dat_o, ackrx_o,
        output acktx_i, validrx_i, dat_i
    );

endinterface

// File: rtl/ep_fifo.sv
// Show-ahead synchronous FIFO; pointers carry an extra MSB to tell full from empty.
// A push while full is accepted when a pop happens in the same cycle.
module ep_fifo #(
    parameter int W     = 7,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Empty reads as zero so the host data output is clean out of reset.
    assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/dev_endpoint.sv
// Device endpoint: host TX FIFO feeding the port's validtx/acktx handshake, and
// port frames captured via validrx/ackrx into a host-readable RX FIFO.
module dev_endpoint
    import ep_pkg::*;
#(
    parameter int DW      = 4,
    parameter int TXDEPTH = 4,
    parameter int RXDEPTH = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  host_wr_i,
    input  logic [ADR_W-1:0]      host_adr_i,
    input  logic [DW-1:0]         host_dat_i,
    output logic                  host_full_o,
    input  logic                  host_rd_i,
    output logic [DW+ADR_W-1:0]   host_dat_o,
    output logic                  host_empty_o,
    input  logic                  host_clr_i,
    output logic                  tx_timeout_o,
    output logic                  host_ovf_o,
    dev_endpoint_if.master        pif
);

    localparam int FW = DW + ADR_W;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT);

    tx_state_t      tx_state;
    rx_state_t      rx_state;
    logic [CW-1:0]  tmo_cnt;
    logic [FW-1:0]  tx_head;
    logic           tx_empty;
    logic           tx_pop;
    logic           rx_full;
    logic           rx_push;
    logic           ovf_set;
    logic           tmo_set;

    assign tx_pop  = (tx_state == LOAD);
    assign ovf_set = host_wr_i && host_full_o && !tx_pop;
    assign tmo_set = (tx_state == REQ) && (tmo_cnt == TMO_MAX);
    assign rx_push = (rx_state == RIDLE) && pif.validrx_i && !rx_full;

    ep_fifo #(.W(FW), .DEPTH(TXDEPTH)) u_tx_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (host_wr_i),
        .wdata ({host_adr_i, host_dat_i}),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (host_full_o),
        .empty (tx_empty)
    );

    ep_fifo #(.W(FW), .DEPTH(RXDEPTH)) u_rx_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (rx_push),
        .wdata (pif.dat_i),
        .pop   (host_rd_i),
        .rdata (host_dat_o),
        .full  (rx_full),
        .empty (host_empty_o)
    );

    // TX: the frame stays registered on adr_o/dat_o for as long as the port withholds acktx.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tx_state      <= IDLE;
            pif.validtx_o <= 1'b0;
            pif.adr_o     <= '0;
            pif.dat_o     <= '0;
            tmo_cnt       <= '0;
        end else begin
            case (tx_state)
                IDLE: begin
                    if (!tx_empty) tx_state <= LOAD;
                end
                LOAD: begin
                    pif.adr_o     <= tx_head[FW-1:DW];
                    pif.dat_o     <= tx_head[DW-1:0];
                    pif.validtx_o <= 1'b1;
                    tmo_cnt       <= '0;
                    tx_state      <= REQ;
                end
                REQ: begin
                    if (pif.acktx_i) begin
                        pif.validtx_o <= 1'b0;
                        tmo_cnt       <= '0;
                        tx_state      <= GAP;
                    end else if (tmo_cnt != TMO_MAX) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                GAP: begin
                    tx_state <= IDLE;
                end
                default: begin
                    pif.validtx_o <= 1'b0;
                    tmo_cnt       <= '0;
                    tx_state      <= IDLE;
                end
            endcase
        end
    end

    // A set wins over a same-cycle clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tx_timeout_o <= 1'b0;
            host_ovf_o   <= 1'b0;
        end else begin
            tx_timeout_o <= tmo_set | (tx_timeout_o & ~host_clr_i);
            host_ovf_o   <= ovf_set | (host_ovf_o & ~host_clr_i);
        end
    end

    // RX: RWAIT waits for validrx to drop so a held request is captured only once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_state    <= RIDLE;
            pif.ackrx_o <= 1'b0;
        end else begin
            case (rx_state)
                RIDLE: begin
                    if (rx_push) begin
                        pif.ackrx_o <= 1'b1;
                        rx_state    <= RACK;
                    end
                end
                RACK: begin
                    pif.ackrx_o <= 1'b0;
                    rx_state    <= RWAIT;
                end
                RWAIT: begin
                    if (!pif.validrx_i) rx_state <= RIDLE;
                end
                default: begin
                    pif.ackrx_o <= 1'b0;
                    rx_state    <= RIDLE;
                end
            endcase
        end
    end

endmodule
